// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, command payload and op legality check.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 10;
  localparam int unsigned DATA_W   = 32;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 10'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 10'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 10'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 10'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 10'd6;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 10'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 10'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 10'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 10'd10;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 10'd11;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
  } alu_cmd_t;

  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: alu_op_legal = 1'b1;
      default:                                    alu_op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int unsigned idx;

  // Explicit wrap so non-power-of-two N never aliases through truncation.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[PW'(idx)]) begin
        any              = 1'b1;
        gnt[PW'(idx)]    = 1'b1;
        gnt_idx          = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one external combinational ALU among NREQ requesters with a one-deep,
// valid/ready result register carrying requester id and tag.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ALU_OP_W-1:0]  req_op,
  input  logic [NREQ*DATA_W-1:0]    req_rs1,
  input  logic [NREQ*DATA_W-1:0]    req_rs2,
  input  logic [NREQ*TAG_W-1:0]     req_tag,
  output logic [ALU_OP_W-1:0]       alu_op,
  output logic [DATA_W-1:0]         alu_rs1,
  output logic [DATA_W-1:0]         alu_rs2,
  input  logic [DATA_W-1:0]         alu_rd,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [TAG_W-1:0]          res_tag,
  output logic                      res_err
);

  localparam int unsigned ID_W = $clog2(NREQ);

  alu_cmd_t         cmd     [NREQ];
  logic [TAG_W-1:0] tag_arr [NREQ];
  alu_cmd_t         sel;
  logic             sel_legal;
  logic             can_issue;
  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [ID_W-1:0]  rr_ptr;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cmd[i].op  = req_op[i*ALU_OP_W +: ALU_OP_W];
      cmd[i].rs1 = req_rs1[i*DATA_W +: DATA_W];
      cmd[i].rs2 = req_rs2[i*DATA_W +: DATA_W];
      tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Nothing is granted during reset or while a result is stuck in the register.
  assign can_issue = !res_valid || res_ready;
  assign arb_req   = (rst_n && can_issue) ? req_valid : '0;

  rr_arbiter #(.N(NREQ), .PW(ID_W)) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign sel       = cmd[gnt_idx];
  assign sel_legal = alu_op_legal(sel.op);
  assign req_ready = gnt;

  // Illegal ops reach the ALU as op 0 so it never sees an undefined encoding.
  always_comb begin
    alu_op  = '0;
    alu_rs1 = '0;
    alu_rs2 = '0;
    if (gnt_any) begin
      alu_op  = sel_legal ? sel.op : '0;
      alu_rs1 = sel.rs1;
      alu_rs2 = sel.rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_tag   <= '0;
      res_err   <= 1'b0;
    end else if (gnt_any) begin
      rr_ptr    <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      res_valid <= 1'b1;
      res_data  <= sel_legal ? alu_rd : '0;
      res_id    <= gnt_idx;
      res_tag   <= tag_arr[gnt_idx];
      res_err   <= !sel_legal;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbiter and result register.
module tb_alu_issue_arbiter;

  localparam int NREQ  = 2;
  localparam int TAG_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*10-1:0]    req_op = '0;
  logic [NREQ*32-1:0]    req_rs1 = '0;
  logic [NREQ*32-1:0]    req_rs2 = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic [9:0]            alu_op;
  logic [31:0]           alu_rs1, alu_rs2, alu_rd;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [31:0]           res_data;
  logic [$clog2(NREQ)-1:0] res_id;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr = 0;
  logic        m_rv = 1'b0;
  logic [31:0] m_data = '0;
  int          m_id = 0;
  logic [TAG_W-1:0] m_tag = '0;
  logic        m_err = 1'b0;
  int          m_last_g = -1;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_tag(res_tag), .res_err(res_err)
  );

  function automatic logic [31:0] alu_ref(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      10'd1:   return a + b;
      10'd2:   return a - b;
      10'd3:   return a << b[4:0];
      10'd5:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10'd6:   return (a < b) ? 32'd1 : 32'd0;
      10'd7:   return a ^ b;
      10'd8:   return a >> b[4:0];
      10'd9:   return $signed(a) >>> b[4:0];
      10'd10:  return a | b;
      10'd11:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // The external ALU the block shares.
  assign alu_rd = alu_ref(alu_op, alu_rs1, alu_rs2);

  function automatic logic is_legal(input logic [9:0] op);
    return op inside {10'd1, 10'd2, 10'd3, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10, 10'd11};
  endfunction

  function automatic int model_grant();
    if (!rst_n || (m_rv && !res_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [9:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_op[i*10 +: 10]        = op;
    req_rs1[i*32 +: 32]       = a;
    req_rs2[i*32 +: 32]       = b;
    req_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  // Advance the model by one clock edge with the current inputs, then cross that edge.
  task automatic step();
    int g;
    logic [9:0] op;
    g = model_grant();
    m_last_g = g;
    if (!rst_n) begin
      m_ptr = 0; m_rv = 1'b0; m_data = '0; m_id = 0; m_tag = '0; m_err = 1'b0;
    end else if (g >= 0) begin
      op     = req_op[g*10 +: 10];
      m_rv   = 1'b1;
      m_data = is_legal(op) ? alu_ref(op, req_rs1[g*32 +: 32], req_rs2[g*32 +: 32]) : 32'd0;
      m_id   = g;
      m_tag  = req_tag[g*TAG_W +: TAG_W];
      m_err  = !is_legal(op);
      m_ptr  = (g + 1) % NREQ;
    end else if (res_ready) begin
      m_rv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
    set_req(0, 10'd1, 32'd1, 32'd1, 5'd1);
    set_req(1, 10'd1, 32'd2, 32'd2, 5'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      total++; if (alu_op !== '0) begin bad++; $display("FAIL reset_alu_op got=%0d exp=0", alu_op); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      step();
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_ptr0 got=%b exp=01", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", res_valid); end
    step();
  endtask

  task automatic test_single_add();
    req_valid = 2'b01; res_ready = 1'b1;
    set_req(0, 10'd1, 32'd5, 32'd7, 5'd3);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b exp=01", req_ready); end
    total++; if (alu_op !== 10'd1 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin
      bad++; $display("FAIL add_alu_in got=%0d/%0d/%0d exp=1/5/7", alu_op, alu_rs1, alu_rs2); end
    step();
    req_valid = '0;
    @(negedge clk);
    total++; if (res_valid !== 1'b1 || res_data !== 32'd12) begin
      bad++; $display("FAIL add_result got=%b/%0d exp=1/12", res_valid, res_data); end
    total++; if (res_id !== 1'b0 || res_tag !== 5'd3 || res_err !== 1'b0) begin
      bad++; $display("FAIL add_meta got=%0d/%0d/%b exp=0/3/0", res_id, res_tag, res_err); end
    step();
  endtask

  task automatic test_fairness();
    int prev, exp_g;
    req_valid = 2'b11; res_ready = 1'b1;
    set_req(0, 10'd9, 32'h8000_0000, 32'd4, 5'd10);
    set_req(1, 10'd2, 32'd0, 32'd1, 5'd11);
    prev = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_g = (prev < 0) ? model_grant() : 1 - prev;
      total++; if (req_ready !== onehot(exp_g)) begin
        bad++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, onehot(exp_g)); end
      if (prev >= 0) begin
        total++; if (res_data !== ((prev == 1) ? 32'hFFFF_FFFF : 32'hF800_0000) || res_id !== prev[0]) begin
          bad++; $display("FAIL fair_result c=%0d got=%h/%0d exp_id=%0d", c, res_data, res_id, prev); end
      end
      prev = exp_g;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [TAG_W-1:0] t; int id; int g;
    res_ready = 1'b0;
    d = m_data; t = m_tag; id = m_id;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, req_ready); end
      total++; if (res_valid !== 1'b1 || res_data !== d || res_tag !== t || int'(res_id) != id) begin
        bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/%h/%0d", c, res_valid, res_data, res_tag, d, t); end
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    g = model_grant();
    total++; if (req_ready !== onehot(g) || g < 0) begin
      bad++; $display("FAIL bp_release got=%b exp=%b", req_ready, onehot(g)); end
    step();
    @(negedge clk);
    total++; if (res_valid !== 1'b1 || int'(res_id) != g) begin
      bad++; $display("FAIL bp_reload got=%b/%0d exp=1/%0d", res_valid, res_id, g); end
  endtask

  task automatic test_illegal();
    req_valid = 2'b01; res_ready = 1'b1;
    set_req(0, 10'd4, 32'd1, 32'd1, 5'd9);
    @(negedge clk);
    total++; if (req_ready !== 2'b01 || alu_op !== 10'd0) begin
      bad++; $display("FAIL illegal_issue got=%b/%0d exp=01/0", req_ready, alu_op); end
    step();
    req_valid = 2'b11;
    @(negedge clk);
    total++; if (res_valid !== 1'b1 || res_data !== 32'd0 || res_err !== 1'b1 || res_tag !== 5'd9) begin
      bad++; $display("FAIL illegal_result got=%b/%h/%b/%0d exp=1/0/1/9", res_valid, res_data, res_err, res_tag); end
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL illegal_ptr got=%b exp=10", req_ready); end
    step();
  endtask

  task automatic test_reset_mid_op();
    req_valid = 2'b01; res_ready = 1'b1;
    set_req(0, 10'd7, 32'h0000_00F0, 32'h0000_00FF, 5'd7);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_accept got=%b exp=01", req_ready); end
    step();
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    @(negedge clk);
    total++; if (res_valid !== 1'b1 || res_data !== 32'h0F) begin
      bad++; $display("FAIL midrst_held got=%b/%h exp=1/f", res_valid, res_data); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_dropped c=%0d got=%b exp=0", c, res_valid); end
      step();
    end
    req_valid = 2'b11;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_ptr got=%b exp=01", req_ready); end
    step();
  endtask

  task automatic test_random();
    int g;
    logic [9:0] op;
    for (int c = 0; c < 400; c++) begin
      // New request where none is pending or the pending one was just taken.
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || m_last_g == i) begin
          op = 10'($urandom_range(0, 15));
          if (op == 10'd15) op = 10'h200;
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, op, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  TAG_W'($urandom));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = model_grant();
      op = (g >= 0) ? req_op[g*10 +: 10] : 10'd0;
      total++; if (req_ready !== onehot(g)) begin
        bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, onehot(g)); end
      total++; if (alu_op !== ((g >= 0 && is_legal(op)) ? op : 10'd0)) begin
        bad++; $display("FAIL rnd_alu_op c=%0d got=%0d exp_raw=%0d", c, alu_op, op); end
      total++; if (res_valid !== m_rv) begin
        bad++; $display("FAIL rnd_res_valid c=%0d got=%b exp=%b", c, res_valid, m_rv); end
      if (m_rv) begin
        total++; if (res_data !== m_data || int'(res_id) != m_id || res_tag !== m_tag || res_err !== m_err) begin
          bad++; $display("FAIL rnd_result c=%0d got=%h/%0d/%0d/%b exp=%h/%0d/%0d/%b",
                          c, res_data, res_id, res_tag, res_err, m_data, m_id, m_tag, m_err); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fairness();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
